sar_adc_ctrl: RTL and testbench

- Successive-approximation sequencer for the PmodADC front end.
- Drives the serial trial-DAC shift register (ser/sclk/lclk) and the sample/hold line, and reads the comparator after each trial.
- Resolves a RES_BITS code MSB-first and presents it with a one-cycle valid strobe.
- Sits between the audio-interface top level (start tick from the sample-rate timer) and the ADC pins.

---
 rtl/sar_adc_pkg.sv | 32 +++
 rtl/sar_adc_ctrl_sr_frame_tx.sv | 82 ++++++++
 rtl/sar_adc_ctrl.sv | 129 ++++++++++++
 tb/tb_sar_adc_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared states, default sizes and timing formulas for the SAR sequencer.
// SAR_ADC_CTRL_COMP_SYNC_EN adds a 2-flop comparator synchronizer and stretches SETTLE by its depth.
package sar_adc_pkg;

   typedef enum logic [2:0] {IDLE, SAMPLE, LOAD, SHIFT, LATCH, SETTLE, DECIDE, DONE} state_e;

   localparam int RES_BITS_DEF      = 14;
   localparam int FRAME_BITS_DEF    = 16;
   localparam int SCLK_DIV_DEF      = 2;
   localparam int SETTLE_CYCLES_DEF = 8;
   localparam int SH_CYCLES_DEF     = 16;

`ifdef SAR_ADC_CTRL_COMP_SYNC_EN
   localparam int COMP_SYNC_CYCLES = 2;
`else
   localparam int COMP_SYNC_CYCLES = 0;
`endif

   function automatic int bit_cycles(int frame_bits, int sclk_div, int settle_cycles);
      return 2 + (2 * frame_bits + 1) * sclk_div + settle_cycles + COMP_SYNC_CYCLES;
   endfunction

   function automatic int conv_latency(int res_bits, int frame_bits, int sclk_div,
                                       int settle_cycles, int sh_cycles);
      return 1 + sh_cycles + res_bits * bit_cycles(frame_bits, sclk_div, settle_cycles);
   endfunction

   localparam int BIT_CYCLES_DEF = bit_cycles(FRAME_BITS_DEF, SCLK_DIV_DEF, SETTLE_CYCLES_DEF);
   localparam int LATENCY_DEF    = conv_latency(RES_BITS_DEF, FRAME_BITS_DEF, SCLK_DIV_DEF,
                                                SETTLE_CYCLES_DEF, SH_CYCLES_DEF);

endpackage

// File: rtl/sar_adc_ctrl_sr_frame_tx.sv
// sr_frame_tx: shifts one frame MSB-first on ser/sclk, then pulses lclk, with SCLK_DIV-cycle half periods.
module sr_frame_tx #(
   parameter int FRAME_BITS = 16,
   parameter int SCLK_DIV   = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  load_i,
   input  logic [FRAME_BITS-1:0] frame_i,
   output logic                  ser_o,
   output logic                  sclk_o,
   output logic                  lclk_o,
   output logic                  shift_done_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_LATCH} tx_e;

   localparam int DW = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
   localparam int BW = $clog2(FRAME_BITS + 1);

   tx_e                   ph_q, ph_d;
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic [DW-1:0]         div_q, div_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  sclk_q, sclk_d;
   logic                  div_end, bit_end;

   assign div_end = div_q == DW'(SCLK_DIV - 1);
   assign bit_end = sclk_q && bit_q == BW'(FRAME_BITS - 1);

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         ph_q   <= TX_IDLE;
         sr_q   <= '0;
         div_q  <= '0;
         bit_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         ph_q   <= ph_d;
         sr_q   <= sr_d;
         div_q  <= div_d;
         bit_q  <= bit_d;
         sclk_q <= sclk_d;
      end

   // The frame shifts on the falling sclk edge so ser is stable across the whole low half.
   always_comb begin
      ph_d   = ph_q;
      sr_d   = sr_q;
      div_d  = div_q;
      bit_d  = bit_q;
      sclk_d = sclk_q;
      if (load_i) begin
         ph_d   = TX_SHIFT;
         sr_d   = frame_i;
         div_d  = '0;
         bit_d  = '0;
         sclk_d = 1'b0;
      end else if (ph_q != TX_IDLE) begin
         div_d = div_end ? '0 : div_q + DW'(1);
         if (div_end && ph_q == TX_SHIFT) begin
            sclk_d = !sclk_q;
            if (sclk_q) begin
               sr_d  = {sr_q[FRAME_BITS-2:0], 1'b0};
               bit_d = bit_q + BW'(1);
            end
            if (bit_end) ph_d = TX_LATCH;
         end
         if (div_end && ph_q == TX_LATCH) ph_d = TX_IDLE;
      end
   end

   always_comb begin
      ser_o        = sr_q[FRAME_BITS-1];
      sclk_o       = sclk_q;
      lclk_o       = ph_q == TX_LATCH;
      shift_done_o = ph_q == TX_SHIFT && div_end && bit_end;
      done_o       = ph_q == TX_LATCH && div_end;
   end

endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation sequencer driving the PmodADC trial DAC and sample/hold.
// Build option SAR_ADC_CTRL_COMP_SYNC_EN: synchronize comp_i through two flops and extend SETTLE by 2.
module sar_adc_ctrl
   import sar_adc_pkg::*;
#(
   parameter int RES_BITS      = RES_BITS_DEF,
   parameter int FRAME_BITS    = FRAME_BITS_DEF,
   parameter int SCLK_DIV      = SCLK_DIV_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int SH_CYCLES     = SH_CYCLES_DEF
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                start_i,
   output logic                busy_o,
   output logic [RES_BITS-1:0] result_o,
   output logic                valid_o,
   output logic                sh_o,
   output logic                ser_o,
   output logic                sclk_o,
   output logic                lclk_o,
   input  logic                comp_i
);

   localparam int SETTLE_TOT = SETTLE_CYCLES + COMP_SYNC_CYCLES;
   localparam int CMAX       = SH_CYCLES > SETTLE_TOT ? SH_CYCLES : SETTLE_TOT;
   localparam int CW         = $clog2(CMAX + 1);
   localparam int IW         = RES_BITS > 1 ? $clog2(RES_BITS) : 1;

   state_e                state_q, state_d;
   logic [RES_BITS-1:0]   code_q, code_d, result_q, result_d, trial;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  comp, tx_load, tx_shift_done, tx_done;

`ifdef SAR_ADC_CTRL_COMP_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) sync_q <= '0;
      else sync_q <= {sync_q[0], comp_i};

   assign comp = sync_q[1];
`else
   assign comp = comp_i;
`endif

   assign trial = code_q | (RES_BITS'(1) << idx_q);

   sr_frame_tx #(
      .FRAME_BITS(FRAME_BITS),
      .SCLK_DIV  (SCLK_DIV)
   ) u_tx (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .load_i      (tx_load),
      .frame_i     (FRAME_BITS'(trial)),
      .ser_o       (ser_o),
      .sclk_o      (sclk_o),
      .lclk_o      (lclk_o),
      .shift_done_o(tx_shift_done),
      .done_o      (tx_done)
   );

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state_q  <= IDLE;
         code_q   <= '0;
         result_q <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
      end

   // result is registered on the DECIDE->DONE edge so it is already valid alongside valid_o.
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      result_d = result_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q + CW'(1);
      case (state_q)
         IDLE:
            if (start_i) begin
               state_d = SAMPLE;
               code_d  = '0;
               idx_d   = IW'(RES_BITS - 1);
               cnt_d   = '0;
            end
         SAMPLE: if (cnt_q == CW'(SH_CYCLES - 1)) state_d = LOAD;
         LOAD: begin
            code_d  = trial;
            state_d = SHIFT;
         end
         SHIFT: if (tx_shift_done) state_d = LATCH;
         LATCH:
            if (tx_done) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         SETTLE: if (cnt_q == CW'(SETTLE_TOT - 1)) state_d = DECIDE;
         DECIDE: begin
            if (!comp) code_d[idx_q] = 1'b0;
            if (idx_q == '0) begin
               state_d  = DONE;
               result_d = code_d;
            end else begin
               idx_d   = idx_q - IW'(1);
               state_d = LOAD;
            end
         end
         DONE: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o   = state_q != IDLE;
      valid_o  = state_q == DONE;
      sh_o     = state_q == IDLE || state_q == SAMPLE || state_q == DONE;
      tx_load  = state_q == LOAD;
      result_o = result_q;
   end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed checks of the SAR sequencer against a shift-register + comparator model.
module tb_sar_adc_ctrl;

`ifdef SAR_ADC_CTRL_COMP_SYNC_EN
   localparam int LAT = 1 + 16 + 14 * 78;
`else
   localparam int LAT = 1 + 16 + 14 * 76;
`endif

   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, comp;
   logic        busy, valid, sh, ser, sclk, lclk;
   logic [13:0] result;
   logic [15:0] vin = '0, sr = '0, lat = '0;
   int          sclk_cnt = 0, lclk_cnt = 0, valid_cnt = 0;
   int          checks = 0, errors = 0;
   int          k, v0;

   sar_adc_ctrl dut (
      .clk_i   (clk),
      .reset_i (reset),
      .start_i (start),
      .busy_o  (busy),
      .result_o(result),
      .valid_o (valid),
      .sh_o    (sh),
      .ser_o   (ser),
      .sclk_o  (sclk),
      .lclk_o  (lclk),
      .comp_i  (comp)
   );

   always #5 clk = ~clk;

   always @(posedge sclk) begin
      sr       <= {sr[14:0], ser};
      sclk_cnt <= sclk_cnt + 1;
   end

   always @(posedge lclk) begin
      lat      <= sr;
      lclk_cnt <= lclk_cnt + 1;
   end

   always @(posedge clk) if (valid) valid_cnt <= valid_cnt + 1;

   assign comp = lat <= vin;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic convert(input logic [15:0] v, input logic [13:0] exp, input string tag);
      int n, s0, l0, shbad;
      vin   = v;
      s0    = sclk_cnt;
      l0    = lclk_cnt;
      shbad = 0;
      n     = 1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      while (!valid && n < 2000) begin
         if (sh !== (n <= 16)) shbad++;
         @(negedge clk);
         n++;
      end
      check($sformatf("%s_latency", tag), n, LAT);
      check($sformatf("%s_result", tag), result, exp);
      check($sformatf("%s_sh_done", tag), sh, 1);
      check($sformatf("%s_sh_profile", tag), shbad, 0);
      check($sformatf("%s_last_frame", tag), lat, {2'b00, exp | 14'h0001});
      check($sformatf("%s_lclk_edges", tag), lclk_cnt - l0, 14);
      check($sformatf("%s_sclk_edges", tag), sclk_cnt - s0, 14 * 16);
      @(negedge clk);
      check($sformatf("%s_valid_width", tag), valid, 0);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ctl", {busy, valid, sh, ser, sclk, lclk}, 6'b001000);
      check("reset_result", result, 0);
      reset = 1'b0;
      @(negedge clk);

      convert(16'h2A52, 14'h2A52, "c2a52");
      convert(16'h0000, 14'h0000, "zero");
      convert(16'h3FFF, 14'h3FFF, "full");

      vin   = 16'h0155;
      start = 1'b1;
      @(negedge clk);
      wait_valid(k);
      check("b2b_first_result", result, 14'h0155);
      @(negedge clk);
      k = 1;
      while (!valid && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("b2b_spacing", k, LAT + 1);
      start = 1'b0;
      @(negedge clk);
      check("b2b_busy_after", busy, 0);

      vin = 16'h0AAA;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (300) @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_valid(k);
      check("ignore_latency", k + 304, LAT);
      check("ignore_result", result, 14'h0AAA);
      start = 1'b1;
      @(negedge clk);
      check("done_start_ignored", busy, 0);
      start = 1'b0;
      v0 = valid_cnt;
      repeat (20) @(negedge clk);
      check("no_extra_conv_busy", busy, 0);
      check("no_extra_conv_valid", valid_cnt - v0, 0);

      vin = 16'h3000;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (499) @(negedge clk);
      check("pre_abort_busy", busy, 1);
      v0    = valid_cnt;
      reset = 1'b1;
      #1;
      check("abort_ctl", {busy, valid, sh, ser, sclk, lclk}, 6'b001000);
      check("abort_result", result, 0);
      @(negedge clk) reset = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_no_valid", valid_cnt - v0, 0);
      check("abort_idle", busy, 0);
      convert(16'h1234, 14'h1234, "after_abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
